// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline types and constants for the hazard sequencer
package cpu_pipe_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [31:0] NOP_INSTR = 32'b0;
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the datapath and pipeline-register controls back to it
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    import cpu_pipe_pkg::*;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_write_reg;
    logic                  ex_branch_taken;
    logic                  dm_req;
    logic                  dm_ready;
    logic                  pc_en;
    logic                  ifid_en;
    logic                  idex_en;
    logic                  exmem_en;
    logic                  memwb_en;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  wb_suppress;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cycles;
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_reg, ex_branch_taken, dm_req, dm_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, wb_suppress,
               mem_timeout, stall_cycles
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_reg, ex_branch_taken, dm_req, dm_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, wb_suppress,
               mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use detection between the EX load and the ID instruction
module hazard_detect
    import cpu_pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    output logic                  load_use
);
    assign load_use = ex_mem_read && (ex_write_reg != '0) &&
                      ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline enable/flush sequencer with memory-wait watchdog; PIPE_PERF_CNT_EN adds the stall counter
module pipe_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 8,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);
    // {pc, ifid, idex, exmem, memwb enables, ifid_flush, idex_flush, wb_suppress}
    localparam logic [7:0] CTL_RST    = 8'b00000_111;
    localparam logic [7:0] CTL_FREEZE = 8'b00000_001;
    localparam logic [7:0] CTL_BRANCH = 8'b11111_110;
    localparam logic [7:0] CTL_BUBBLE = 8'b00111_010;
    localparam logic [7:0] CTL_RUN    = 8'b11111_000;
    state_t            state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              mem_timeout, set_to, load_use, mem_stall;
    logic [7:0]        ctl;
    hazard_detect u_hazard (
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_uses_rt   (bus.id_uses_rt),
        .ex_mem_read  (bus.ex_mem_read),
        .ex_write_reg (bus.ex_write_reg),
        .load_use     (load_use)
    );
    assign mem_stall = bus.dm_req && !bus.dm_ready;
    // Control vector in priority order; reset overrides everything without a clock
    assign ctl = !rst_n            ? CTL_RST    :
                 (state == HALT)   ? CTL_FREEZE :
                 mem_stall         ? CTL_FREEZE :
                 bus.ex_branch_taken ? CTL_BRANCH :
                 load_use          ? CTL_BUBBLE : CTL_RUN;
    assign {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.wb_suppress} = ctl;
    assign bus.mem_timeout = mem_timeout;
    // Memory-wait FSM next state and watchdog count
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        set_to   = 1'b0;
        if (state == RUN && mem_stall) begin
            state_nx = MEM_WAIT;
            wait_nx  = WAIT_W'(1);
        end else if (state == MEM_WAIT) begin
            if (bus.dm_ready) begin
                state_nx = RUN;
                wait_nx  = '0;
            end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                state_nx = HALT;
                set_to   = 1'b1;
            end else begin
                wait_nx = wait_cnt + WAIT_W'(1);
            end
        end
    end
    // State, watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_nx;
            mem_timeout <= mem_timeout | set_to;
        end
    end
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    // Saturating count of cycles where the PC is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (!ctl[7] && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
    assign bus.stall_cycles = stall_cnt;
`else
    assign bus.stall_cycles = CNT_W'(0);
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (MAX_WAIT=4)
module tb_pipe_hazard_ctrl;
    localparam logic [7:0] RST_O  = 8'b00000_111;
    localparam logic [7:0] FRZ_O  = 8'b00000_001;
    localparam logic [7:0] BR_O   = 8'b11111_110;
    localparam logic [7:0] LU_O   = 8'b00111_010;
    localparam logic [7:0] RUN_O  = 8'b11111_000;

    typedef struct {
        logic [7:0]  ctl;
        logic        to;
        logic [15:0] sc;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] sc_model = '0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus();
    pipe_hazard_ctrl #(.MAX_WAIT(4), .WAIT_W(8), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [15:0] sc_exp();
`ifdef PIPE_PERF_CNT_EN
        return sc_model;
`else
        return 16'd0;
`endif
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ut, input logic mr,
                         input logic [4:0] wr, input logic br, input logic dq, input logic dr);
        bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = ut; bus.ex_mem_read = mr;
        bus.ex_write_reg = wr; bus.ex_branch_taken = br; bus.dm_req = dq; bus.dm_ready = dr;
    endtask

    task automatic push(input logic [7:0] ctl, input logic to, input string tag);
        exp_t e;
        e.ctl = ctl; e.to = to; e.sc = sc_exp(); e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        logic [7:0] got;
        e = sb.pop_front();
        got = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
               bus.ifid_flush, bus.idex_flush, bus.wb_suppress};
        tests++;
        assert (got === e.ctl) else begin
            fails++;
            $error("FAIL %s ctl got %b exp %b", e.tag, got, e.ctl);
        end
        tests++;
        assert (bus.mem_timeout === e.to) else begin
            fails++;
            $error("FAIL %s mem_timeout got %b exp %b", e.tag, bus.mem_timeout, e.to);
        end
        tests++;
        assert (bus.stall_cycles === e.sc) else begin
            fails++;
            $error("FAIL %s stall_cycles got %0d exp %0d", e.tag, bus.stall_cycles, e.sc);
        end
    endtask

    // one cycle: drive after the edge, check mid-cycle, then advance past the next edge
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic ut, input logic mr,
                        input logic [4:0] wr, input logic br, input logic dq, input logic dr,
                        input logic [7:0] ctl, input logic to, input string tag);
        drive(rs, rt, ut, mr, wr, br, dq, dr);
        push(ctl, to, tag);
        #4;
        compare();
        if (!ctl[7] && rst_n) sc_model++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, RST_O, 0, "reset0");
        step(0, 0, 0, 1, 5, 1, 1, 0, RST_O, 0, "reset1");
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 0, "idle");
        step(5, 0, 0, 1, 5, 0, 0, 0, LU_O,  0, "loaduse_rs");
        step(5, 0, 0, 0, 0, 0, 0, 0, RUN_O, 0, "after_bubble");
        step(0, 0, 0, 1, 0, 0, 0, 0, RUN_O, 0, "load_r0");
        step(3, 7, 1, 1, 7, 0, 0, 0, LU_O,  0, "loaduse_rt");
        step(3, 7, 0, 1, 7, 0, 0, 0, RUN_O, 0, "rt_unused");
        step(5, 0, 0, 1, 5, 1, 0, 0, BR_O,  0, "branch_over_lu");
        step(0, 0, 0, 0, 0, 0, 1, 1, RUN_O, 0, "dm_same_cycle");
        step(0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 0, "memwait1");
        step(0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 0, "memwait2");
        step(0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 0, "memwait3");
        step(0, 0, 0, 0, 0, 0, 1, 1, RUN_O, 0, "mem_ready");
        step(0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 0, "back_to_run");
        step(5, 0, 0, 1, 5, 1, 1, 0, FRZ_O, 0, "stall_masks_all");
        step(5, 0, 0, 1, 5, 1, 1, 1, BR_O,  0, "ready_with_branch");
        step(5, 0, 0, 1, 5, 0, 0, 0, LU_O,  0, "lu_after_release");
        step(0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 0, "to_wait1");
        step(0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 0, "to_wait2");
        step(0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 0, "to_wait3");
        step(0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 0, "to_wait4");
        step(0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 0, "to_wait5");
        step(0, 0, 0, 0, 0, 0, 0, 1, FRZ_O, 1, "halt_ignores_ready");
        step(5, 0, 0, 1, 5, 1, 0, 0, FRZ_O, 1, "halt_ignores_branch");
        rst_n = 1'b0;
        sc_model = '0;
        push(RST_O, 0, "halt_async_reset");
        #1;
        compare();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 0, "run_after_halt");
        step(0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 0, "wait_before_reset1");
        step(0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 0, "wait_before_reset2");
        rst_n = 1'b0;
        sc_model = '0;
        push(RST_O, 0, "async_reset_midwait");
        #1;
        compare();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 0, "run_after_reset");
        step(0, 0, 0, 0, 0, 0, 0, 1, RUN_O, 0, "ready_in_run");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
